bcd_scheduler: RTL and testbench

- Shares one `bcd` binary-to-BCD converter between N_REQ requesters, e.g. score, lives and frame counters in the 6-bit VGA overlay.
- Arbitrates round-robin, sequences the converter's load/ready handshake and writes each result into a per-requester digit register read by the text renderer.
- Sits between the game-state logic and `bcd`. `bcd` is instantiated beside this block and connected through the bcd_* ports.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/rr_pick.sv | 29 ++
 rtl/bcd_scheduler.sv | 138 +++++++++++++
 tb/tb_bcd_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared widths, FSM state encoding and timing constants for the BCD scheduler.
package bcd_pkg;

    localparam int NUMBER_W   = 16;
    localparam int DIGIT_W    = 4;
    localparam int N_DIGITS   = 5;
    localparam int BCD_W      = DIGIT_W * N_DIGITS;

    // Cycles the scheduler waits for the converter to drop ready after a load.
    localparam int BUSY_GRACE = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request strictly after
// the pointer (wrapping modulo N_REQ) wins. The pointer itself is checked last.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_pointer,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any_req
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down to pointer+1 so the nearest request wins.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_pointer) + k) % N_REQ);
            if (i_req[w_idx]) begin
                o_grant   = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_scheduler.sv
// Shares one binary-to-BCD converter between N_REQ requesters: round-robin
// arbitration, load/ready handshake sequencing and per-requester result slots.
module bcd_scheduler
    import bcd_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*NUMBER_W-1:0] number,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ*BCD_W-1:0]    digits,
    output logic [N_REQ-1:0]          valid,
    output logic                      err,
    output logic                      busy,
    output logic                      bcd_load,
    output logic [NUMBER_W-1:0]       bcd_number,
    input  logic                      bcd_ready,
    input  logic [BCD_W-1:0]          bcd_digits
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_grant;
    logic [NUMBER_W-1:0]  r_number;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic [N_REQ-1:0]     r_valid;
    logic [BCD_W-1:0]     r_slot [N_REQ];

    logic [IDX_W-1:0]     w_grant;
    logic                 w_any_req;
    logic                 w_capture_now;
    logic                 w_timeout;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_pointer (r_ptr),
        .o_grant   (w_grant),
        .o_any_req (w_any_req)
    );

    // Result lands in the slot on the WAIT_DONE->CAPTURE edge so it is visible with ack.
    assign w_capture_now = (r_state == WAIT_DONE) && bcd_ready;
    assign w_timeout     = (r_state == WAIT_DONE) && !bcd_ready
                           && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic for the handshake sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_any_req) w_state_next = LOAD;
            LOAD:      w_state_next = WAIT_BUSY;
            WAIT_BUSY: if (!bcd_ready || (r_cnt == CNT_W'(BUSY_GRACE - 1)))
                           w_state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (bcd_ready)      w_state_next = CAPTURE;
                else if (w_timeout) w_state_next = IDLE;
            end
            CAPTURE:   w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // State register, grant/operand latch, wait counter, pointer and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_grant  <= '0;
            r_number <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_any_req) begin
                        r_grant  <= w_grant;
                        r_number <= number[w_grant*NUMBER_W +: NUMBER_W];
                    end
                end
                WAIT_BUSY: begin
                    if (w_state_next == WAIT_DONE) r_cnt <= '0;
                    else                           r_cnt <= r_cnt + CNT_W'(1);
                end
                WAIT_DONE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_err <= 1'b1;
                        r_ptr <= r_grant;
                    end
                end
                CAPTURE: r_ptr <= r_grant;
                default: ;
            endcase
        end
    end

    // Per-requester result slots; only the granted slot is ever written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < N_REQ; s++) r_slot[s] <= '0;
        end else if (w_capture_now) begin
            for (int s = 0; s < N_REQ; s++) begin
                if (r_grant == IDX_W'(s)) begin
                    r_slot[s]  <= bcd_digits;
                    r_valid[s] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign digits[gi*BCD_W +: BCD_W] = r_slot[gi];
            assign ack[gi]   = (r_state == CAPTURE) && (r_grant == IDX_W'(gi));
            assign valid[gi] = r_valid[gi];
        end
    endgenerate

    assign err        = r_err;
    assign busy       = (r_state != IDLE);
    assign bcd_load   = (r_state == LOAD);
    assign bcd_number = r_number;

endmodule

// File: tb/tb_bcd_scheduler.sv
// Scoreboard bench for bcd_scheduler with a behavioural converter model.
module tb_bcd_scheduler;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*16-1:0] number = '0;
    logic [N-1:0]  ack;
    logic [N*20-1:0] digits;
    logic [N-1:0]  valid;
    logic          err;
    logic          busy;
    logic          bcd_load;
    logic [15:0]   bcd_number;
    logic          m_ready;
    logic [19:0]   m_digits;

    always #5 clk = ~clk;

    bcd_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .number     (number),
        .ack        (ack),
        .digits     (digits),
        .valid      (valid),
        .err        (err),
        .busy       (busy),
        .bcd_load   (bcd_load),
        .bcd_number (bcd_number),
        .bcd_ready  (m_ready),
        .bcd_digits (m_digits)
    );

    // Converter model: ready drops one cycle after load, rises LAT cycles later.
    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        logic [19:0] r;
        int t;
        r = '0;
        t = int'(v);
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    logic        hang = 1'b0;
    logic [15:0] m_op;
    int          m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_ready  <= 1'b1;
            m_cnt    <= 0;
            m_digits <= '0;
            m_op     <= '0;
        end else if (bcd_load) begin
            m_ready <= 1'b0;
            m_cnt   <= LAT;
            m_op    <= bcd_number;
        end else if (!m_ready && !hang) begin
            if (m_cnt <= 1) begin
                m_ready  <= 1'b1;
                m_digits <= to_bcd(m_op);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        int          slot;
        logic [19:0] d;
    } exp_t;

    exp_t        ack_q[$];
    logic [15:0] load_q[$];
    int checks  = 0;
    int errors  = 0;
    int n_acks  = 0;
    int n_loads = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_conv(input int slot, input logic [15:0] n, input logic [19:0] d);
        exp_t e;
        e.slot = slot;
        e.d    = d;
        load_q.push_back(n);
        ack_q.push_back(e);
    endtask

    // Monitor: compares every load and ack against the queued expectations.
    initial begin
        logic        prev_load;
        logic [19:0] shadow [N];
        logic [N-1:0] shadow_valid;
        logic [15:0] exp_n;
        exp_t        e;
        prev_load    = 1'b0;
        shadow_valid = '0;
        for (int i = 0; i < N; i++) shadow[i] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < N; i++) shadow[i] = '0;
                shadow_valid = '0;
                prev_load    = 1'b0;
            end else begin
                if (bcd_load) begin
                    n_loads++;
                    chk("load_single_cycle", 32'(prev_load), 32'd0);
                    if (load_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_load: got bcd_number %0d required no load", bcd_number);
                    end else begin
                        exp_n = load_q.pop_front();
                        chk("bcd_number", 32'(bcd_number), 32'(exp_n));
                    end
                end
                prev_load = bcd_load;
                if (ack != '0) begin
                    n_acks++;
                    if (ack_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got ack %b required none", ack);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_slot", 32'(ack), 32'(1) << e.slot);
                        shadow[e.slot]       = e.d;
                        shadow_valid[e.slot] = 1'b1;
                        for (int i = 0; i < N; i++)
                            chk($sformatf("digits_slot%0d", i), 32'(digits[i*20 +: 20]), 32'(shadow[i]));
                        chk("valid", 32'(valid), 32'(shadow_valid));
                        $display("ack slot %0d digits %h valid %b", e.slot, digits[e.slot*20 +: 20], valid);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_num(input int s, input logic [15:0] v);
        number[s*16 +: 16] = v;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k;
        k = 0;
        while (n_acks < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("ack_count_reached", 32'(n_acks >= target), 32'd1);
    endtask

    task automatic wait_loads(input int target, input int budget);
        int k;
        k = 0;
        while (n_loads < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("load_count_reached", 32'(n_loads >= target), 32'd1);
    endtask

    task automatic wait_err(input int budget);
        int k;
        k = 0;
        while (!err && k < budget) begin
            tick(1);
            k++;
        end
        chk("err_raised", 32'(err), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},        32'(ack), 32'd0);
        chk({tag, "_digits_lo"},  digits[31:0], 32'd0);
        chk({tag, "_digits_hi"},  32'(digits[79:32]), 32'd0);
        chk({tag, "_valid"},      32'(valid), 32'd0);
        chk({tag, "_err"},        32'(err), 32'd0);
        chk({tag, "_busy"},       32'(busy), 32'd0);
        chk({tag, "_bcd_load"},   32'(bcd_load), 32'd0);
        chk({tag, "_bcd_number"}, 32'(bcd_number), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_a;
        int base_l;

        do_reset(3);
        check_all_zero("reset");

        // Single request, 20-cycle converter.
        set_num(0, 16'd12345);
        expect_conv(0, 16'd12345, 20'h12345);
        req = 4'b0001;
        wait_acks(1, 200);
        req = 4'b0000;
        tick(1);
        chk("t1_valid", 32'(valid), 32'b0001);
        chk("t1_loads", 32'(n_loads), 32'd1);
        tick(3);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // All requesters held high: order 0,1,2,3,0.
        do_reset(1);
        set_num(0, 16'd1);
        set_num(1, 16'd22);
        set_num(2, 16'd333);
        set_num(3, 16'd65535);
        expect_conv(0, 16'd1,     20'h00001);
        expect_conv(1, 16'd22,    20'h00022);
        expect_conv(2, 16'd333,   20'h00333);
        expect_conv(3, 16'd65535, 20'h65535);
        expect_conv(0, 16'd1,     20'h00001);
        req = 4'b1111;
        wait_acks(6, 600);
        req = 4'b0000;
        tick(3);
        chk("t2_loads", 32'(n_loads), 32'd6);

        // Operand change mid-conversion only affects the next round.
        set_num(1, 16'd100);
        expect_conv(1, 16'd100, 20'h00100);
        expect_conv(1, 16'd200, 20'h00200);
        req = 4'b0010;
        wait_loads(7, 50);
        tick(5);
        set_num(1, 16'd200);
        wait_acks(8, 300);
        req = 4'b0000;
        tick(3);

        // Converter hangs: timeout sets err, no ack, slot untouched.
        hang = 1'b1;
        set_num(0, 16'd7);
        load_q.push_back(16'd7);
        req = 4'b0001;
        wait_err(200);
        req = 4'b0000;
        tick(2);
        hang = 1'b0;
        tick(25);
        chk("t4_no_ack", 32'(n_acks), 32'd8);
        chk("t4_slot0_kept", 32'(digits[19:0]), 32'h00001);
        chk("t4_valid", 32'(valid), 32'b1111);
        set_num(1, 16'd42);
        expect_conv(1, 16'd42, 20'h00042);
        req = 4'b0010;
        wait_acks(9, 200);
        req = 4'b0000;
        tick(2);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // Reset during WAIT_DONE aborts; back-to-back reset stays quiet.
        set_num(2, 16'd999);
        load_q.push_back(16'd999);
        base_l = n_loads;
        req = 4'b0100;
        wait_loads(base_l + 1, 50);
        tick(5);
        reset = 1'b1;
        req   = 4'b0000;
        tick(1);
        reset = 1'b0;
        check_all_zero("t5_abort");
        base_a = n_acks;
        tick(30);
        chk("t5_no_ack", 32'(n_acks), 32'(base_a));
        do_reset(2);
        tick(3);
        check_all_zero("t5_b2b");
        expect_conv(2, 16'd999, 20'h00999);
        req = 4'b0100;
        wait_acks(base_a + 1, 200);
        req = 4'b0000;
        tick(3);

        // One-cycle req[3] pulse during a conversion is never served.
        set_num(0, 16'd5);
        set_num(3, 16'd77);
        expect_conv(0, 16'd5, 20'h00005);
        base_l = n_loads;
        base_a = n_acks;
        req = 4'b0001;
        wait_loads(base_l + 1, 50);
        tick(3);
        req = 4'b1001;
        tick(1);
        req = 4'b0001;
        wait_acks(base_a + 1, 200);
        req = 4'b0000;
        tick(30);
        chk("t6_acks", 32'(n_acks), 32'(base_a + 1));
        chk("t6_loads", 32'(n_loads), 32'(base_l + 1));
        chk("t6_valid3", 32'(valid[3]), 32'd0);
        chk("t6_valid", 32'(valid), 32'b0101);

        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("load_queue_drained", 32'(load_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
